// File: rtl/game_spawn_pkg.sv
// Shared types and constants for the sprite spawn scheduler.
// Covers the FSM state encoding, the LFSR polynomial and the candidate coordinate slices.
package game_spawn_pkg;

    typedef enum logic [1:0] {StIdle, StDraw, StWrite, StDone} spawn_state_e;

    localparam int unsigned LfsrWidth = 16;
    localparam int unsigned LfsrTap0 = 15;
    localparam int unsigned LfsrTap1 = 13;
    localparam int unsigned LfsrTap2 = 12;
    localparam int unsigned LfsrTap3 = 10;
    localparam logic [LfsrWidth-1:0] LfsrDefaultSeed = 16'hACE1;

    // Candidate x is the low 10 bits; candidate y is the top 7 bits, zero-extended.
    localparam int unsigned XcMsb = 9;
    localparam int unsigned XcLsb = 0;
    localparam int unsigned YcMsb = 15;
    localparam int unsigned YcLsb = 9;

    function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] l);
        return {l[LfsrWidth-2:0], l[LfsrTap0] ^ l[LfsrTap1] ^ l[LfsrTap2] ^ l[LfsrTap3]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR that shifts left every cycle.
// A zero seed would lock the register, so the default seed is used in its place.
module lfsr16 import game_spawn_pkg::*; #(
    parameter logic [LfsrWidth-1:0] SEED = LfsrDefaultSeed
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [LfsrWidth-1:0] state_o
);

    localparam logic [LfsrWidth-1:0] ResetVal = (SEED == '0) ? LfsrDefaultSeed : SEED;

    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= ResetVal;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/sprite_spawn_scheduler.sv
// Walks the enabled sprites in ascending order and loads each one with a random spawn point.
// Rejected draws are retried a bounded number of times before falling back to the window corner.
module sprite_spawn_scheduler import game_spawn_pkg::*; #(
    parameter int unsigned       N_SPRITES = 4,
    parameter int unsigned       X_MIN     = 0,
    parameter int unsigned       X_MAX     = 608,
    parameter int unsigned       Y_MIN     = 0,
    parameter int unsigned       Y_MAX     = 120,
    parameter logic signed [1:0] DY        = 2'sb01,
    parameter int unsigned       MAX_RETRY = 7,
    parameter logic [15:0]       SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_SPRITES-1:0] mask,
    output logic                 busy,
    output logic                 done,
    output logic [N_SPRITES-1:0] write_xy,
    output logic [N_SPRITES-1:0] write_dxy,
    output logic [9:0]           x,
    output logic [9:0]           y,
    output logic [1:0]           dx,
    output logic [1:0]           dy
);

    localparam int unsigned IdxW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

    spawn_state_e         state_q, state_d;
    logic [N_SPRITES-1:0] mask_q, mask_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [3:0]           retry_q, retry_d;
    logic [9:0]           x_q, x_d, y_q, y_d;
    logic [1:0]           dx_q, dx_d, dy_q, dy_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [N_SPRITES-1:0] wr_q, wr_d;

    logic [LfsrWidth-1:0] lfsr;
    logic [9:0]           x_c, y_c;
    logic [31:0]          x_off, y_off;
    logic                 in_win;
    logic [IdxW-1:0]      first_set, next_set;
    logic                 next_found;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    assign x_c = lfsr[XcMsb:XcLsb];
    assign y_c = {3'b000, lfsr[YcMsb:YcLsb]};

    // Offsets wrap to huge values below the minimum, so one compare covers both bounds.
    always_comb begin
        x_off  = 32'(x_c) - X_MIN;
        y_off  = 32'(y_c) - Y_MIN;
        in_win = (x_off <= (X_MAX - X_MIN)) && (y_off <= (Y_MAX - Y_MIN));
    end

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        first_set  = '0;
        next_set   = '0;
        next_found = 1'b0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_set = IdxW'(i);
            end
            if (mask_q[i] && (i > int'(idx_q))) begin
                next_set   = IdxW'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d = mask;
                    if (mask == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = first_set;
                        retry_d = 4'd0;
                        state_d = StDraw;
                    end
                end
            end
            StDraw: begin
                if (in_win || (retry_q == 4'(MAX_RETRY))) begin
                    x_d     = in_win ? x_c : 10'(X_MIN);
                    y_d     = in_win ? y_c : 10'(Y_MIN);
                    dx_d    = lfsr[0] ? 2'b01 : 2'b11;
                    dy_d    = DY;
                    state_d = StWrite;
                end else begin
                    retry_d = retry_q + 4'd1;
                end
            end
            StWrite: begin
                if (next_found) begin
                    idx_d   = next_set;
                    retry_d = 4'd0;
                    state_d = StDraw;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state and registered alongside it.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        for (int i = 0; i < N_SPRITES; i++) begin
            wr_d[i] = (state_d == StWrite) && (idx_d == IdxW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            idx_q   <= '0;
            retry_q <= 4'd0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            dx_q    <= 2'd0;
            dy_q    <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign write_xy  = wr_q;
    assign write_dxy = wr_q;
    assign x         = x_q;
    assign y         = y_q;
    assign dx        = dx_q;
    assign dy        = dy_q;

endmodule
